fb_access_scheduler: RTL
========================

# fb_access_scheduler

Owns the single port of the 320×320×12-bit frame-buffer BRAM and shares it between two requesters:
- the VGA scan-out path, which reads and always has priority;
- the image loader, which streams pixels in over a valid/ready handshake and is written in raster order.

It also holds the filter-mode and threshold configuration in shadow registers and commits them only at frame start, so a mode change never tears mid-frame. It sits between the pixel-stream source, the BRAM and the VGA display/filter datapath.

## Interface
Parameters:
- IMG_W, 320, image width in pixels
- IMG_H, 320, image height in pixels
- ADDR_W, 17, BRAM address width; must satisfy IMG_W*IMG_H ≤ 2^ADDR_W
- DATA_W, 12, pixel width (4:4:4)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse at start of vertical blank
- disp_req  in  1  display read request this cycle
- disp_addr  in  ADDR_W  display read address
- disp_rdata  out  DATA_W  read data; passthrough of bram_rdata
- disp_rvalid  out  1  disp_rdata valid, one cycle after a granted read
- load_start  in  1  one-cycle pulse that begins an image load
- wr_valid  in  1  loader pixel valid
- wr_data  in  DATA_W  loader pixel
- wr_ready  out  1  scheduler accepts the pixel this cycle
- loading  out  1  high while a load is in progress
- load_done  out  1  one-cycle pulse after the final pixel is written
- cfg_choice  in  2  requested filter mode
- cfg_threshold  in  DATA_W  requested threshold
- choice_q  out  2  committed filter mode
- threshold_q  out  DATA_W  committed threshold
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  DATA_W  BRAM write data
- bram_rdata  in  DATA_W  BRAM read data; one-cycle registered latency

## Operation
- State machine with three states: IDLE, LOAD, DONE.
  - IDLE → LOAD on load_start. The write pointer wptr clears to 0 on this transition.
  - LOAD → DONE on the accepted write with wptr = IMG_W*IMG_H−1.
  - DONE → IDLE unconditionally after one cycle. load_done is high for that cycle.
  - load_start in LOAD or DONE is ignored.
- loading = (state == LOAD).
- Port arbitration is combinational each cycle:
  - Display grant: disp_req = 1. Drives bram_en = 1, bram_we = 0, bram_addr = disp_addr.
  - Write grant: disp_req = 0, state = LOAD and wr_valid = 1. Drives bram_en = 1, bram_we = 1, bram_addr = wptr, bram_wdata = wr_data.
  - Otherwise bram_en = 0, bram_we = 0, bram_addr = 0, bram_wdata = 0.
- wr_ready = (state == LOAD) && !disp_req.
  - A pixel transfers when wr_valid && wr_ready; wptr then increments by 1.
  - The loader may hold wr_valid high indefinitely. While wr_ready is low, wr_data must stay stable.
- A display request arriving simultaneously with wr_valid always wins. The write stalls and is neither lost nor duplicated.
- wptr never wraps. It stops at IMG_W*IMG_H−1, and the final write forces the transition to DONE.
- Display reads are accepted in any state, including LOAD. Data read during a load may mix the old and new image; the display path decides whether to blank using loading.
- Configuration commit:
  - On frame_start, choice_q ← cfg_choice and threshold_q ← cfg_threshold.
  - Between frame_start pulses, cfg_* changes have no effect.
- Reset: asynchronous and may be asserted mid-load. It returns the block to IDLE with:
  - wptr = 0, disp_rvalid = 0, load_done = 0;
  - choice_q = 2'b00 (original colours), threshold_q = 0.
  - Combinational outputs then follow the IDLE rules above: wr_ready = 0, loading = 0, bram_en = 0, bram_we = 0.
  - Pixels already written stay in the BRAM. A fresh load_start is required to resume loading.

## Timing
- Read latency: granted read in cycle N → disp_rdata valid with disp_rvalid = 1 in cycle N+1. Back-to-back reads give one datum per cycle.
- Write latency: zero. The BRAM write occurs on the same edge as the handshake.
- After the final handshake in cycle N: state = DONE and load_done = 1 in cycle N+1; IDLE and loading = 0 in cycle N+2.
- Config outputs update on the clock edge where frame_start is sampled high and are visible the next cycle.
- Full-image load with no display contention takes IMG_W*IMG_H handshake cycles plus one DONE cycle.

## Structure
- Shared package `fb_pkg`:
  - constants IMG_W, IMG_H, IMG_PIXELS = IMG_W*IMG_H, ADDR_W, DATA_W;
  - the state enum;
  - filter-mode encodings: ORIG = 0, NEG = 1, THRESH = 2, GRAY = 3.
- One natural sub-module, `fb_cfg_shadow`: the frame-synchronous shadow register pair for choice and threshold.
- The arbiter, FSM and write pointer stay in the top module.

## Test plan
- Reset mid-load: assert reset after 100 accepted pixels.
  - Immediately: loading = 0, wr_ready = 0, choice_q = 0.
  - A new load_start then writes its first pixel to address 0.
- Uncontended load with IMG_W = IMG_H = 4: load_start, then 16 pixels 12'h000..12'h00F with wr_valid held high.
  - Writes land at addresses 0..15 with data equal to the address.
  - load_done pulses exactly once, one cycle after the 16th handshake.
- Contention: disp_req = 1 with disp_addr = 5 while wr_valid = 1 in LOAD.
  - bram_we = 0, bram_addr = 5, wr_ready = 0.
  - The next cycle, disp_rvalid = 1.
  - The pending pixel writes once, only after disp_req drops, with wptr unchanged.
- Back-to-back reads at addresses 7, 8, 9 in consecutive cycles give disp_rvalid high for three consecutive cycles, with data returned in order.
- Config commit: change cfg_choice to 2'b11 and cfg_threshold to 12'h7FF mid-frame.
  - choice_q and threshold_q are unchanged until frame_start.
  - They hold 2'b11 and 12'h7FF the cycle after frame_start.
- Ignored start: a load_start pulse during LOAD does not reset wptr, and the load completes after exactly IMG_W*IMG_H transfers.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants, state encoding and filter-mode encodings for the frame-buffer scheduler.
package fb_pkg;

    localparam int IMG_W      = 320;
    localparam int IMG_H      = 320;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } fb_state_e;

    localparam logic [1:0] ORIG   = 2'd0;
    localparam logic [1:0] NEG    = 2'd1;
    localparam logic [1:0] THRESH = 2'd2;
    localparam logic [1:0] GRAY   = 2'd3;

endpackage

// File: rtl/fb_cfg_shadow.sv
// Frame-synchronous shadow registers: the requested filter mode and threshold
// only take effect at frame start, so the display never sees a mid-frame change.
module fb_cfg_shadow #(
    parameter int DATA_W = fb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [1:0]        cfg_choice,
    input  logic [DATA_W-1:0] cfg_threshold,
    output logic [1:0]        choice_q,
    output logic [DATA_W-1:0] threshold_q
);
    import fb_pkg::*;

    logic [1:0]        choice_d;
    logic [DATA_W-1:0] threshold_d;

    // Hold the committed values except on the frame-start pulse.
    always_comb begin
        choice_d    = choice_q;
        threshold_d = threshold_q;
        if (frame_start) begin
            choice_d    = cfg_choice;
            threshold_d = cfg_threshold;
        end
    end

    // Committed configuration; reset selects the original colours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            choice_q    <= ORIG;
            threshold_q <= '0;
        end else begin
            choice_q    <= choice_d;
            threshold_q <= threshold_d;
        end
    end

endmodule

// File: rtl/fb_access_scheduler.sv
// Single-port frame-buffer owner: display reads always win the port, the image
// loader writes in raster order whenever the port is free, and the filter
// configuration is committed once per frame.
//
// state | meaning
// IDLE  | no load in progress; only display reads use the port
// LOAD  | loader pixels accepted when the display is not reading
// DONE  | final pixel written; load_done high for this one cycle
module fb_access_scheduler #(
    parameter int IMG_W  = fb_pkg::IMG_W,
    parameter int IMG_H  = fb_pkg::IMG_H,
    parameter int ADDR_W = fb_pkg::ADDR_W,
    parameter int DATA_W = fb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              loading,
    output logic              load_done,
    input  logic [1:0]        cfg_choice,
    input  logic [DATA_W-1:0] cfg_threshold,
    output logic [1:0]        choice_q,
    output logic [DATA_W-1:0] threshold_q,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);
    import fb_pkg::*;

    localparam int                N_PIX     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic              wr_fire;

    assign wr_ready    = (state_q == LOAD) && !disp_req;
    assign wr_fire     = wr_valid && wr_ready;
    assign loading     = (state_q == LOAD);
    assign load_done   = (state_q == DONE);
    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = bram_rdata;

    // Load sequencing and write pointer; the pointer parks on the last pixel
    // rather than wrapping, and that final write ends the load.
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        disp_rvalid_d = disp_req;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                end
            end
            LOAD: begin
                if (wr_fire) begin
                    if (wptr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port arbitration: display read has absolute priority over loader write.
    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        if (disp_req) begin
            bram_en   = 1'b1;
            bram_addr = disp_addr;
        end else if ((state_q == LOAD) && wr_valid) begin
            bram_en    = 1'b1;
            bram_we    = 1'b1;
            bram_addr  = wptr_q;
            bram_wdata = wr_data;
        end
    end

    // State, write pointer and read-valid pipeline stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            disp_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            disp_rvalid_q <= disp_rvalid_d;
        end
    end

    fb_cfg_shadow #(
        .DATA_W (DATA_W)
    ) u_cfg_shadow (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .cfg_choice    (cfg_choice),
        .cfg_threshold (cfg_threshold),
        .choice_q      (choice_q),
        .threshold_q   (threshold_q)
    );

endmodule
